// File: rtl/l1_dcache_assoc.sv
// l1_dcache_assoc: N-way set-associative write-back/write-allocate L1 data cache with tree-PLRU; DCACHE_PERF_COUNTERS_EN adds hit/miss/writeback counters
module l1_dcache_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_W/8-1:0] mem_byte_enable,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_resp,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [LINE_W-1:0]   pmem_wdata,
  input  logic [LINE_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count,
  output logic [15:0]         writeback_count
`endif
);
  localparam int BYTES = DATA_W / 8;
  localparam int WORDS = LINE_W / DATA_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int BYTE_W = $clog2(BYTES);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int WAY_W = $clog2(WAYS);
  typedef logic [BYTES-1:0][7:0] word_t;
  typedef word_t [WORDS-1:0] line_t;
  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state;
  line_t data [SETS][WAYS];
  logic [TAG_W-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [WAYS-1:1] plru [SETS];
  logic [WAYS-1:1] plru_upd;
  logic [WAY_W-1:0] victim, hit_way, miss_way;
  logic [WAY_W:0] n, m;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WSEL_W-1:0] wsel;
  logic req, hit, unused;
  line_t hit_line, merged;
  word_t wd;
  assign {tag, idx} = mem_address[ADDR_W-1:OFF_W];
  assign wsel = mem_address[OFF_W-1:BYTE_W];
  assign unused = ^mem_address;
  assign req = mem_read | mem_write;
  assign wd = mem_wdata;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
  end
  always_comb begin
    n = '0;
    n[0] = 1'b1;
    for (int l = 0; l < WAY_W; l++) n = {n[WAY_W-1:0], plru[idx][n[WAY_W-1:0]]};
    miss_way = n[WAY_W-1:0];
    for (int w = WAYS - 1; w >= 0; w--) if (!valid[idx][w]) miss_way = WAY_W'(w);
    plru_upd = plru[idx];
    m = {1'b1, hit_way};
    for (int l = 0; l < WAY_W; l++) begin
      plru_upd[m[WAY_W:1]] = ~m[0];
      m = m >> 1;
    end
  end
  assign hit_line = data[idx][hit_way];
  always_comb begin
    merged = hit_line;
    for (int b = 0; b < BYTES; b++) merged[wsel][b] = mem_byte_enable[b] ? wd[b] : hit_line[wsel][b];
  end
  assign mem_rdata = hit_line[wsel];
  assign mem_resp = !reset && state == COMPARE && req && hit;
  assign pmem_read = state == ALLOCATE;
  assign pmem_write = state == WRITEBACK;
  assign pmem_wdata = data[idx][victim];
  assign pmem_address = state == WRITEBACK ? {tags[idx][victim], idx, {OFF_W{1'b0}}} :
                        state == ALLOCATE  ? {tag, idx, {OFF_W{1'b0}}} : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COMPARE;
      victim <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      if (state == COMPARE && req && hit) begin
        plru[idx] <= plru_upd;
        if (mem_write) begin
          data[idx][hit_way] <= merged;
          dirty[idx][hit_way] <= 1'b1;
        end
      end
      if (state == COMPARE && req && !hit) begin
        victim <= miss_way;
        state <= valid[idx][miss_way] && dirty[idx][miss_way] ? WRITEBACK : ALLOCATE;
      end
      if (state == WRITEBACK && pmem_resp) state <= ALLOCATE;
      if (state == ALLOCATE && pmem_resp) begin
        data[idx][victim] <= pmem_rdata;
        tags[idx][victim] <= tag;
        valid[idx][victim] <= 1'b1;
        dirty[idx][victim] <= 1'b0;
        state <= COMPARE;
      end
    end
  end
`ifdef DCACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
      writeback_count <= '0;
    end else begin
      if (mem_resp && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == COMPARE && req && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      if (state == WRITEBACK && pmem_resp && writeback_count != 16'hFFFF) writeback_count <= writeback_count + 16'd1;
    end
  end
`endif
endmodule

// File: doc/l1_dcache_assoc.md
# l1_dcache_assoc

Parametrised N-way set-associative, write-back, write-allocate L1 data cache between the LC-3b datapath memory port and physical memory. It generalises the direct-mapped data cache to configurable ways, sets, word width and line width, adds pseudo-LRU replacement and a synchronous reset that invalidates the whole array. Sits in the same slot as the existing data cache, CPU side toward the pipeline MEM stage and line-wide side toward pmem or the L2.

## Interface
- WAYS, 2, associativity; power of two, ≥2
- SETS, 8, sets per way; power of two, ≥2
- ADDR_W, 16, address width in bits
- DATA_W, 16, CPU word width in bits; multiple of 8
- LINE_W, 128, line width in bits; power-of-two multiple of DATA_W
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  DATA_W/8  byte write mask
- mem_address  in  ADDR_W  byte address; held stable during a request
- mem_wdata  in  DATA_W  write data
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  read data, valid with mem_resp
- pmem_address  out  ADDR_W  line-aligned physical address
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  LINE_W  victim line data
- pmem_rdata  in  LINE_W  fill data, valid with pmem_resp
- pmem_resp  in  1  pmem completion

## Operation
- Address split: offset = log2(LINE_W/8) LSBs, index = next log2(SETS) bits, tag = remaining MSBs. Word select = offset bits above log2(DATA_W/8).
- Per way/set: valid, dirty, tag, line. Per set: WAYS-1 tree-PLRU bits.
- FSM states: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE: on request, tag compare all ways in parallel. Hit → mem_resp=1 this cycle; read returns selected word; write merges enabled bytes, sets dirty; PLRU updated to mark hit way MRU. Miss → victim = lowest-index invalid way, else PLRU way; dirty victim → WRITEBACK, clean → ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata=victim line; on pmem_resp → ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={req tag, index, 0}; on pmem_resp write pmem_rdata into victim, valid=1, dirty=0, tag=req tag → COMPARE, where request then hits.
- mem_read and mem_write both high: treated as a write.
- pmem_resp outside WRITEBACK/ALLOCATE: ignored.
- No request in COMPARE: no state change, no PLRU update.

## Timing
- Reset: state=COMPARE; all valid, dirty, PLRU bits cleared; mem_resp, pmem_read, pmem_write=0; pmem_address=0.
- Hit latency: 0 cycles (mem_resp same cycle request presented in COMPARE).
- Clean miss: mem_resp one cycle after the pmem_resp of the fill.
- Dirty miss: writeback handshake, then fill handshake, then mem_resp next cycle.
- pmem_read/pmem_write are state-decoded, never both high; deassert the cycle after pmem_resp.
- Reset mid-WRITEBACK/ALLOCATE: FSM to COMPARE next edge, pmem strobes low, in-flight request dropped, no mem_resp.
- mem_rdata undefined when mem_resp=0.

## Configuration
- DCACHE_PERF_COUNTERS_EN defined: adds outputs hit_count, miss_count, writeback_count (each 16 bits, out), incremented on hit mem_resp, on COMPARE→miss transition, on WRITEBACK pmem_resp; saturate at 0xFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, read 0x0014, pmem returns 0x...0007_0006_0005_0004_0003_0002_0001_0000 → pmem_read with pmem_address 0x0010; mem_resp with mem_rdata 0x0002 one cycle after pmem_resp.
- After fill, write 0x0014 data 0xABCD mask 2'b01, then read 0x0014 → two hit responses, no pmem traffic, mem_rdata 0x00CD.
- Fill 0x0010 then 0x0090 (set 1, both ways), read 0x0010, read 0x0110 → victim is 0x0090 line; clean → only pmem_read 0x0110.
- Dirty 0x0090 then miss 0x0110 after touching 0x0010 → pmem_write address 0x0090 with modified line, then pmem_read 0x0110, then mem_resp.
- Assert reset while pmem_write high → pmem_write 0 next cycle; subsequent read 0x0010 misses (pmem_read 0x0010).
- With DCACHE_PERF_COUNTERS_EN, run scenario 4 from reset → hit_count, miss_count, writeback_count match issued hits/misses; writeback_count=1.
